// File: rtl/icache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl_if
//
// Bus bundle between the refill controller, instruction memory and the
// instruction cache write port.
//
// Signals:
//   mem_req     controller -> memory   read request, held until completed
//   mem_addr    controller -> memory   word address of the request
//   mem_rvalid  memory -> controller   mem_rdata valid, completes the request
//   mem_rdata   memory -> controller   read data
//   cache_we    controller -> cache    write one data word (1-cycle pulse)
//   cache_waddr controller -> cache    word address for cache_we / tag_we
//   cache_wdata controller -> cache    data word for cache_we
//   tag_we      controller -> cache    write tag + set valid for line at
//                                      cache_waddr (1-cycle pulse)
//
// Handshake: mem_req is raised with a stable mem_addr and both stay unchanged
// until a cycle in which mem_rvalid=1; that cycle transfers mem_rdata and
// completes the request. The controller may present the next address (with
// mem_req still high) in the very next cycle. mem_rvalid while mem_req=0 is
// ignored. cache_we/tag_we are fire-and-forget single-cycle strobes.
// ---------------------------------------------------------------------------
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              cache_we;
    logic [ADDR_W-1:0] cache_waddr;
    logic [DATA_W-1:0] cache_wdata;
    logic              tag_we;

    // Controller side
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata,
        output cache_we,
        output cache_waddr,
        output cache_wdata,
        output tag_we
    );

    // Memory / cache side
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata,
        input  cache_we,
        input  cache_waddr,
        input  cache_wdata,
        input  tag_we
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Instruction-cache miss/refill sequencer. On a fetch miss it stalls the PC,
// reads the whole line word-by-word (offset 0 upward) from instruction
// memory, writes each word into the cache, then writes the tag/valid entry
// and releases the stall. A refill cannot be aborted by a redirect; the new
// PC is evaluated once the controller is back in IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   fetch_valid  fetch stage presents a valid PC
//   fetch_pc     current PC (word address)
//   cache_hit    cache lookup result for fetch_pc
//   pc_stall     hold PC / fetch register (combinational)
//   refill_busy  controller is not in IDLE
//   miss_count   serviced misses, saturating at 0xFFFF
//   state_dbg    current FSM state encoding (IDLE=0, FILL=1, COMMIT=2)
//   bus          memory request / cache write bundle (master side)
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_valid,
    input  logic [ADDR_W-1:0]   fetch_pc,
    input  logic                cache_hit,
    output logic                pc_stall,
    output logic                refill_busy,
    output logic [15:0]         miss_count,
    output logic [1:0]          state_dbg,
    icache_refill_ctrl_if.master bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       miss_count_q, miss_count_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              cache_we_q, cache_we_d;
    logic [ADDR_W-1:0] cache_waddr_q, cache_waddr_d;
    logic [DATA_W-1:0] cache_wdata_q, cache_wdata_d;
    logic              tag_we_q, tag_we_d;

    logic [OFF_W-1:0]  cnt_inc;
    logic              miss;

    assign cnt_inc = cnt_q + OFF_W'(1);
    assign miss    = fetch_valid & ~cache_hit;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        miss_count_d  = miss_count_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        cache_we_d    = 1'b0;
        cache_waddr_d = cache_waddr_q;
        cache_wdata_d = cache_wdata_q;
        tag_we_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss) begin
                    // Line base: PC with the word-offset bits cleared.
                    base_d     = fetch_pc & ~OFF_MASK;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc & ~OFF_MASK;
                    state_d    = FILL;
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                end
            end
            FILL: begin
                if (bus.mem_rvalid) begin
                    cache_we_d    = 1'b1;
                    cache_waddr_d = base_q | ADDR_W'(cnt_q);
                    cache_wdata_d = bus.mem_rdata;
                    // cnt wraps to 0 on the last word, ready for the next line.
                    cnt_d         = cnt_inc;
                    if (cnt_q == LAST_OFF) begin
                        mem_req_d = 1'b0;
                        state_d   = COMMIT;
                    end else begin
                        // Next word is requested back-to-back with no gap.
                        mem_addr_d = base_q | ADDR_W'(cnt_inc);
                    end
                end
            end
            COMMIT: begin
                // The last data word is being written this cycle, so the tag
                // strobe goes out one cycle later to keep them disjoint.
                tag_we_d      = 1'b1;
                cache_waddr_d = base_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            base_q        <= '0;
            miss_count_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            cache_we_q    <= 1'b0;
            cache_waddr_q <= '0;
            cache_wdata_q <= '0;
            tag_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            miss_count_q  <= miss_count_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            cache_we_q    <= cache_we_d;
            cache_waddr_q <= cache_waddr_d;
            cache_wdata_q <= cache_wdata_d;
            tag_we_q      <= tag_we_d;
        end
    end

    // Stall is combinational so a fresh miss freezes the PC in the same cycle.
    assign pc_stall        = rst_n & ((state_q != IDLE) | miss);
    assign refill_busy     = (state_q != IDLE);
    assign miss_count      = miss_count_q;
    assign state_dbg       = state_q;

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.cache_we    = cache_we_q;
    assign bus.cache_waddr = cache_waddr_q;
    assign bus.cache_wdata = cache_wdata_q;
    assign bus.tag_we      = tag_we_q;
endmodule
